riscv_commit_tracer: RTL

- Producer side of the CPU retirement-check interface: samples each retired instruction of the single-cycle RISC-V core (pc, rd_addr, regWrite, write_back_data, store info).
- Encodes each retirement as a tagged trace record and buffers it in a FIFO.
- Streams records to a checker or scoreboard over a valid/ready handshake, appending an end-of-program marker when the core retires END_PC.

---
 rtl/riscv_commit_tracer_if.sv | 43 ++++
 rtl/riscv_commit_tracer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/riscv_commit_tracer_if.sv
// Retire-side inputs, trace stream and status of the commit tracer bundled as one port.
// master = tracer (drives trace/status), slave = core + consumer side.
interface riscv_commit_tracer_if #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16
);
  logic                     retire_valid;
  logic [31:0]              pc;
  logic [4:0]               rd_addr;
  logic                     regWrite;
  logic [31:0]              write_back_data;
  logic                     mem_write;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;

  logic                     trace_valid;
  logic                     trace_ready;
  logic [1:0]               trace_kind;
  logic [31:0]              trace_pc;
  logic [4:0]               trace_rd;
  logic [31:0]              trace_addr;
  logic [31:0]              trace_data;
  logic [SEQ_W-1:0]         trace_seq;

  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     overflow;
  logic [7:0]               drop_count;
  logic                     done;

  modport master (
    input  retire_valid, pc, rd_addr, regWrite, write_back_data,
           mem_write, mem_addr, mem_wdata, trace_ready,
    output trace_valid, trace_kind, trace_pc, trace_rd, trace_addr,
           trace_data, trace_seq, fifo_level, overflow, drop_count, done
  );

  modport slave (
    output retire_valid, pc, rd_addr, regWrite, write_back_data,
           mem_write, mem_addr, mem_wdata, trace_ready,
    input  trace_valid, trace_kind, trace_pc, trace_rd, trace_addr,
           trace_data, trace_seq, fifo_level, overflow, drop_count, done
  );
endinterface

// File: rtl/riscv_commit_tracer.sv
// Encodes retired instructions into tagged trace records, buffers them, and streams them out.
// One cycle from retire to trace_valid when empty; full FIFO drops records, trace_* hold while not ready.
module riscv_commit_tracer #(
  parameter int          DEPTH  = 8,
  parameter logic [31:0] END_PC = 32'h080,
  parameter int          SEQ_W  = 16
) (
  input logic                   clk,
  input logic                   reset,
  riscv_commit_tracer_if.master tif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] K_REG     = 2'd0;
  localparam logic [1:0] K_STORE   = 2'd1;
  localparam logic [1:0] K_NOWRITE = 2'd2;
  localparam logic [1:0] K_END     = 2'd3;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [1:0]       kind;
    logic [31:0]      pc;
    logic [4:0]       rd;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [SEQ_W-1:0] seq;
  } rec_t;

  state_t           state_q, state_d;
  logic             end_pending_q, end_pending_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  rec_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q;
  logic [7:0]       drop_cnt_q;

  rec_t new_rec;
  rec_t head;
  rec_t out_rec;
  logic empty, full, pop, can_push, push, drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign head     = mem_q[rd_ptr_q];
  assign pop      = !empty && tif.trace_ready;
  assign can_push = !full || pop;

  always_comb begin
    new_rec = '0;
    if (state_q == S_RUN) begin
      new_rec.pc  = tif.pc;
      new_rec.seq = seq_q;
      // A write to x0 is architecturally invisible, so it is classed as NOWRITE.
      if (tif.regWrite && (tif.rd_addr != 5'd0)) begin
        new_rec.kind = K_REG;
        new_rec.rd   = tif.rd_addr;
        new_rec.data = tif.write_back_data;
      end else if (tif.mem_write) begin
        new_rec.kind = K_STORE;
        new_rec.addr = tif.mem_addr;
        new_rec.data = tif.mem_wdata;
      end else begin
        new_rec.kind = K_NOWRITE;
      end
    end else begin
      new_rec.kind = K_END;
      new_rec.pc   = END_PC;
      new_rec.seq  = seq_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    end_pending_d = end_pending_q;
    seq_d         = seq_q;
    push          = 1'b0;
    drop          = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (tif.retire_valid) begin
          seq_d = seq_q + SEQ_W'(1);
          if (can_push) push = 1'b1;
          else          drop = 1'b1;
          if (tif.pc == END_PC) begin
            end_pending_d = 1'b1;
            state_d       = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (end_pending_q && can_push) begin
          push          = 1'b1;
          end_pending_d = 1'b0;
        end
        if (pop && (head.kind == K_END)) state_d = S_DONE;
      end
      S_DONE: ;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_RUN;
      end_pending_q <= 1'b0;
      seq_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      end_pending_q <= end_pending_d;
      seq_q         <= seq_d;
      count_q       <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= new_rec;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Stale entries behind the head are masked so an empty FIFO presents all-zero fields.
  assign out_rec = empty ? '0 : head;

  assign tif.trace_valid = !empty;
  assign tif.trace_kind  = out_rec.kind;
  assign tif.trace_pc    = out_rec.pc;
  assign tif.trace_rd    = out_rec.rd;
  assign tif.trace_addr  = out_rec.addr;
  assign tif.trace_data  = out_rec.data;
  assign tif.trace_seq   = out_rec.seq;
  assign tif.fifo_level  = count_q;
  assign tif.overflow    = overflow_q;
  assign tif.drop_count  = drop_cnt_q;
  assign tif.done        = (state_q == S_DONE);

endmodule
